// File: rtl/internal_mem_p.sv
// Parametrised synchronous RAM: port A read/write with byte masking, port B read-only.
// A clear sequencer zero-fills the array after every reset before accepting requests.
module internal_mem_p #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                enable,
  input  logic                wEnable,
  input  logic [WORD_W/8-1:0] byteMask,
  input  logic [WORD_W-1:0]   newWord,
  output logic [WORD_W-1:0]   wordOut,
  output logic                wordValid,
  input  logic [ADDR_W-1:0]   bAddr,
  input  logic                bEnable,
  output logic [WORD_W-1:0]   bWordOut,
  output logic                bWordValid,
  output logic                addrErr
);

  localparam int unsigned       NBytes  = WORD_W / 8;
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic [WORD_W-1:0]   word_out_q, b_word_out_q;
  logic                word_valid_q, b_word_valid_q, addr_err_q;

  logic                a_req, b_req, a_in, b_in, a_wr;
  logic [ADDR_W-1:0]   a_idx, b_idx;
  logic [WORD_W-1:0]   a_old, a_merged, a_rdata, b_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Next state: walk the clear pointer once over the array, then serve requests
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    unique case (state_q)
      StInit: begin
        if (clear_ptr_q == LastIdx) state_d = StRun;
        else clear_ptr_d = clear_ptr_q + 1'b1;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    ready = (state_q == StRun);
  end

  always_comb begin
    a_req = (state_q == StRun) && enable;
    b_req = (state_q == StRun) && bEnable;
    a_in  = {1'b0, addr} < DepthW;
    b_in  = {1'b0, bAddr} < DepthW;
    a_wr  = a_req && wEnable && a_in;
    // Out-of-range indices are steered to 0 so the array is never read past its end
    a_idx = a_in ? addr : '0;
    b_idx = b_in ? bAddr : '0;
    a_old = mem[a_idx];
  end

  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NBytes; i++) begin
      if (wEnable && byteMask[i]) a_merged[8*i +: 8] = newWord[8*i +: 8];
    end
  end

  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    if (a_in) a_rdata = (RDW_MODE != 0) ? a_merged : a_old;
    if (b_in) begin
      if ((RDW_MODE != 0) && a_wr && (bAddr == addr)) b_rdata = a_merged;
      else b_rdata = mem[b_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) mem[clear_ptr_q] <= '0;
      else if (a_wr) mem[a_idx] <= a_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_out_q     <= '0;
      b_word_out_q   <= '0;
      word_valid_q   <= 1'b0;
      b_word_valid_q <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      word_valid_q   <= a_req;
      b_word_valid_q <= b_req;
      addr_err_q     <= (a_req && !a_in) || (b_req && !b_in);
      if (a_req) word_out_q <= a_rdata;
      if (b_req) b_word_out_q <= b_rdata;
    end
  end

  assign wordOut    = word_out_q;
  assign wordValid  = word_valid_q;
  assign bWordOut   = b_word_out_q;
  assign bWordValid = b_word_valid_q;
  assign addrErr    = addr_err_q;

endmodule

// File: tb/tb_internal_mem_p.sv
// Directed bench for internal_mem_p: two instances (DEPTH 256 / old-data, DEPTH 200 / new-data)
// share stimulus; a behavioural model queues expected outputs that are checked after each edge.
module tb_internal_mem_p;

  logic        clk = 1'b0;
  logic        rst = 1'b0, enable = 1'b0, wEnable = 1'b0, bEnable = 1'b0;
  logic [7:0]  addr = '0, bAddr = '0;
  logic [1:0]  byteMask = '0;
  logic [15:0] newWord = '0;

  logic        ready0, wv0, bv0, err0, ready1, wv1, bv1, err1;
  logic [15:0] wo0, bo0, wo1, bo1;

  always #5 clk = ~clk;

  internal_mem_p #(.WORD_W(16), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .addr(addr), .enable(enable), .wEnable(wEnable),
    .byteMask(byteMask), .newWord(newWord), .wordOut(wo0), .wordValid(wv0), .bAddr(bAddr),
    .bEnable(bEnable), .bWordOut(bo0), .bWordValid(bv0), .addrErr(err0)
  );

  internal_mem_p #(.WORD_W(16), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .addr(addr), .enable(enable), .wEnable(wEnable),
    .byteMask(byteMask), .newWord(newWord), .wordOut(wo1), .wordValid(wv1), .bAddr(bAddr),
    .bEnable(bEnable), .bWordOut(bo1), .bWordValid(bv1), .addrErr(err1)
  );

  typedef struct packed {
    logic        rdy;
    logic [15:0] wo;
    logic        wv;
    logic [15:0] bo;
    logic        bv;
    logic        err;
  } exp_t;

  logic [15:0] mdl [2][256];
  bit          run_m [2];
  int          cnt_m [2];
  logic [15:0] lwo [2];
  logic [15:0] lbo [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          n_asrt = 0;
  int          n_fail = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic bit rdw(input int k);
    return k != 0;
  endfunction

  task automatic predict(input int k, output exp_t e);
    logic [15:0] old, merged;
    bit a_in, b_in;
    e = '0;
    e.wo = lwo[k];
    e.bo = lbo[k];
    if (rst) begin
      e.wo = '0;
      e.bo = '0;
    end else if (run_m[k]) begin
      a_in = int'(addr) < dep(k);
      b_in = int'(bAddr) < dep(k);
      old = a_in ? mdl[k][addr] : 16'h0000;
      merged = old;
      if (wEnable) begin
        for (int i = 0; i < 2; i++) if (byteMask[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      if (enable) begin
        e.wv = 1'b1;
        e.wo = !a_in ? 16'h0000 : (rdw(k) ? merged : old);
        if (!a_in) e.err = 1'b1;
      end
      if (bEnable) begin
        e.bv = 1'b1;
        if (!b_in) begin
          e.bo = 16'h0000;
          e.err = 1'b1;
        end else if (rdw(k) && enable && wEnable && a_in && bAddr == addr) e.bo = merged;
        else e.bo = mdl[k][bAddr];
      end
      if (enable && wEnable && a_in) mdl[k][addr] = merged;
    end
    lwo[k] = e.wo;
    lbo[k] = e.bo;
    if (rst) begin
      run_m[k] = 1'b0;
      cnt_m[k] = 0;
    end else if (!run_m[k]) begin
      cnt_m[k]++;
      if (cnt_m[k] == dep(k)) begin
        run_m[k] = 1'b1;
        for (int j = 0; j < 256; j++) mdl[k][j] = 16'h0000;
      end
    end
    e.rdy = run_m[k];
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    logic        rdy, wv, bv, err;
    logic [15:0] wo, bo;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_asrt++;
      n_fail++;
      $error("FAIL d%0d.queue observed=empty expected=entry", k);
      return;
    end
    if (k == 0) begin
      e = q0.pop_front();
      rdy = ready0; wo = wo0; wv = wv0; bo = bo0; bv = bv0; err = err0;
    end else begin
      e = q1.pop_front();
      rdy = ready1; wo = wo1; wv = wv1; bo = bo1; bv = bv1; err = err1;
    end
    chk($sformatf("d%0d.ready", k), 16'(rdy), 16'(e.rdy));
    chk($sformatf("d%0d.wordOut", k), wo, e.wo);
    chk($sformatf("d%0d.wordValid", k), 16'(wv), 16'(e.wv));
    chk($sformatf("d%0d.bWordOut", k), bo, e.bo);
    chk($sformatf("d%0d.bWordValid", k), 16'(bv), 16'(e.bv));
    chk($sformatf("d%0d.addrErr", k), 16'(err), 16'(e.err));
  endtask

  task automatic step(input bit r, input bit en, input bit we, input logic [7:0] a,
                      input logic [1:0] m, input logic [15:0] d, input bit be,
                      input logic [7:0] ba);
    exp_t e;
    rst = r; enable = en; wEnable = we; addr = a; byteMask = m; newWord = d;
    bEnable = be; bAddr = ba;
    predict(0, e);
    q0.push_back(e);
    predict(1, e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    pop_check(0);
    pop_check(1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 16'h0000, 1'b0, 8'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] m, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b1, a, m, d, 1'b0, 8'd0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b1, 1'b0, a, 2'b00, 16'h0000, 1'b0, 8'd0);
  endtask

  task automatic brd(input logic [7:0] ba);
    step(1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 16'h0000, 1'b1, ba);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      run_m[k] = 1'b0; cnt_m[k] = 0; lwo[k] = '0; lbo[k] = '0;
      for (int j = 0; j < 256; j++) mdl[k][j] = 16'h0000;
    end

    // Reset, then clear; a write during INIT must be dropped
    step(1'b1, 1'b0, 1'b0, 8'd0, 2'b00, 16'h0000, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 2'b00, 16'h0000, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd5, 2'b11, 16'hFFFF, 1'b0, 8'd0);
    repeat (258) idle();

    // Port B sweep with a reverse port A sweep alongside
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(255 - i), 2'b00, 16'h0000, 1'b1, 8'(i));
    end
    rd(8'd5);

    // Basic write/read and valid pulse width
    wr(8'd1, 2'b11, 16'd50000);
    rd(8'd1);
    idle();
    idle();

    // Byte masking
    wr(8'd7, 2'b11, 16'hABCD);
    wr(8'd7, 2'b01, 16'h1234);
    rd(8'd7);
    wr(8'd7, 2'b00, 16'hFFFF);
    rd(8'd7);
    wr(8'd7, 2'b10, 16'h9900);
    brd(8'd7);

    // Collision of A write and B read on the same address
    wr(8'd3, 2'b11, 16'h1111);
    step(1'b0, 1'b1, 1'b1, 8'd3, 2'b11, 16'h5555, 1'b1, 8'd3);
    rd(8'd3);
    brd(8'd3);

    // Out of range (only the DEPTH=200 instance)
    wr(8'd199, 2'b11, 16'h2222);
    wr(8'd10, 2'b11, 16'h3333);
    rd(8'd210);
    wr(8'd210, 2'b11, 16'h7777);
    rd(8'd199);
    rd(8'd10);
    rd(8'd210);
    step(1'b0, 1'b1, 1'b0, 8'd220, 2'b00, 16'h0000, 1'b1, 8'd230);
    brd(8'd250);
    step(1'b0, 1'b1, 1'b0, 8'd210, 2'b00, 16'h0000, 1'b1, 8'd5);
    idle();

    // Reset in the middle of a back-to-back read stream
    wr(8'd1, 2'b11, 16'hBEEF);
    rd(8'd1);
    step(1'b0, 1'b1, 1'b0, 8'd2, 2'b00, 16'h0000, 1'b1, 8'd1);
    step(1'b1, 1'b1, 1'b0, 8'd1, 2'b00, 16'h0000, 1'b1, 8'd1);
    repeat (260) step(1'b0, 1'b1, 1'b0, 8'd1, 2'b00, 16'h0000, 1'b1, 8'd1);
    rd(8'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
